cnn_mac_pipe: RTL and testbench
===============================

Name: cnn_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for CNN convolution and dense dot products.
- Generalises the fixed-width combinational DSP48 multiplier:
  - configurable operand, accumulator and output widths
  - configurable multiplier pipeline depth
  - dot-product framing with a last flag
  - rounded, saturating fixed-point output
  - valid/ready handshake with backpressure
- Sits between the line-buffer/weight fetch logic and the activation/pooling stage.

Parameters:
- A_WIDTH, 10: signed activation operand width.
- B_WIDTH, 14: signed weight operand width.
- NUM_STAGE, 3: multiplier pipeline registers, >=1.
- ACC_WIDTH, 32: signed accumulator width, >= A_WIDTH+B_WIDTH.
- FRAC_SHIFT, 8: right shift applied to the final sum, 0..ACC_WIDTH-1.
- OUT_WIDTH, 16: signed result width, <= ACC_WIDTH.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat.
- in_a  in  A_WIDTH  signed activation.
- in_b  in  B_WIDTH  signed weight.
- in_last  in  1  final beat of the current dot product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_WIDTH  rounded, saturated dot product.
- out_sat  out  1  out_data was clipped.

Behaviour:
- Reset (ap_rst_n low, asynchronous): clears all pipeline valid bits, the accumulator, out_valid, out_data and out_sat to 0. in_ready reads 1 once reset is released. A reset mid dot-product discards the partial sum; the next accepted beat starts a fresh sum.
- Global enable: ce = !out_valid || out_ready. in_ready = ce.
  - A beat is accepted when in_valid && in_ready.
  - When ce=0 every stage holds: operands, product pipe, valid/last bits, accumulator.
- Product: full-precision signed product of width A_WIDTH+B_WIDTH, carried through NUM_STAGE registers along with its valid and last bits. Bubbles (valid=0) flow through without affecting the accumulator.
- Accumulate: when a valid product leaves the pipe with ce=1, sum = acc + sign-extended product, in ACC_WIDTH two's complement (wraps; no accumulator overflow detection).
  - last=0: acc <= sum.
  - last=1: acc <= 0, and sum goes to the output stage in the same cycle.
- Output stage:
  - r = (sum + (FRAC_SHIFT>0 ? 2^(FRAC_SHIFT-1) : 0)) arithmetic-shifted right by FRAC_SHIFT. This is round half toward +infinity, with the rounding add done at ACC_WIDTH+1 bits.
  - r is clipped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; out_sat = 1 when clipped.
  - out_data, out_sat and out_valid are registered.
- Latency: a last beat accepted at cycle t gives out_valid=1 at t+NUM_STAGE+1 when there is no stall.
- Throughput: one beat per cycle. A one-beat dot product (in_last on every beat) yields one result per cycle.
- Output hold: out_valid/out_data/out_sat stay stable until out_valid && out_ready. If a new result arrives in the same cycle the current one is consumed, out_valid stays 1 with the new data.
- Beats accepted with in_valid low are ignored. in_last with no preceding beats gives a single-product result.

Test Plan:
- Single beat: (a=3, b=256, last=1) -> out_data=3, out_sat=0, out_valid exactly NUM_STAGE+1 cycles after acceptance.
- Three-beat dot product: (100,200),(-50,300),(7,-1000,last) -> sum -2000 -> out_data=-8, out_sat=0. Accumulator is cleared so the following single beat (1,256,last) gives 1.
- Positive saturation: 8 beats of (-512,-8192), last on the 8th -> sum 33554432 -> out_data=32767, out_sat=1. Negative: 8 beats of (-512,8191) -> out_data=-32768, out_sat=1.
- Backpressure: out_ready=0 for 5 cycles while beats stream with last every beat -> in_ready drops, out_data holds, no result lost or duplicated. After release, results emerge in order, one per cycle.
- Bubbles: in_valid toggling 1/0 within a 4-beat dot product of (1,1) -> out_data=0 (sum 4 >>8 rounds to 0). Repeat with FRAC_SHIFT=0 build -> out_data=4.
- Reset mid-operation: assert ap_rst_n low after 2 of 4 beats and while a result is pending -> out_valid drops immediately (asynchronous). A fresh 1-beat (2,512,last) afterwards gives out_data=4, with no residue from the aborted sum.

Source files
------------

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed multiply-accumulate for convolution and
// dense dot products. Products flow through a NUM_STAGE register pipe into
// an accumulator; the last beat of a dot product is rounded, saturated and
// held in a registered output stage behind a valid/ready handshake. One
// global enable stalls every stage together when the output is blocked.
module cnn_mac_pipe #(
  parameter int A_WIDTH    = 10,
  parameter int B_WIDTH    = 14,
  parameter int NUM_STAGE  = 3,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   in_a,
  input  logic signed [B_WIDTH-1:0]   in_b,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat
);

  localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;
  // One extra bit so the rounding add cannot overflow.
  localparam int RND_WIDTH  = ACC_WIDTH + 1;

  // Half an output LSB; zero when no fractional bits are dropped.
  localparam logic signed [RND_WIDTH-1:0] RND_BIAS =
    (FRAC_SHIFT == 0) ? '0 : (RND_WIDTH'(1) << ((FRAC_SHIFT == 0) ? 0 : FRAC_SHIFT - 1));

  // Clip bounds of the signed output range, expressed at rounding width.
  localparam logic signed [RND_WIDTH-1:0] OUT_MAX =
    {{(RND_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [RND_WIDTH-1:0] OUT_MIN =
    {{(RND_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic                         ce;
  logic signed [PROD_WIDTH-1:0] a_ext;
  logic signed [PROD_WIDTH-1:0] b_ext;
  logic signed [PROD_WIDTH-1:0] prod_next;

  logic signed [PROD_WIDTH-1:0] tail_prod;
  logic                         tail_valid;
  logic                         tail_last;

  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic signed [ACC_WIDTH-1:0]  sum_next;
  logic signed [RND_WIDTH-1:0]  sum_ext;
  logic signed [RND_WIDTH-1:0]  rnd_sum_next;
  logic signed [OUT_WIDTH-1:0]  sat_data_next;
  logic                         sat_flag_next;
  logic                         result_fire;

  logic                         out_valid_reg;
  logic signed [OUT_WIDTH-1:0]  out_data_reg;
  logic                         out_sat_reg;

  // The whole datapath advances only when the output register can take a result.
  assign ce       = !out_valid_reg || out_ready;
  assign in_ready = ce;

  // Full-precision product: both operands sign-extended to the product width.
  assign a_ext     = {{B_WIDTH{in_a[A_WIDTH-1]}}, in_a};
  assign b_ext     = {{A_WIDTH{in_b[B_WIDTH-1]}}, in_b};
  assign prod_next = a_ext * b_ext;

  // Product pipe: each stage carries the product with its valid and last bits.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      logic signed [PROD_WIDTH-1:0] prod_reg;
      logic                         valid_reg;
      logic                         last_reg;
      logic signed [PROD_WIDTH-1:0] prod_in;
      logic                         valid_in;
      logic                         last_in;

      if (gi == 0) begin : g_src
        assign prod_in  = prod_next;
        assign valid_in = in_valid;
        assign last_in  = in_last;
      end else begin : g_src
        assign prod_in  = g_stage[gi-1].prod_reg;
        assign valid_in = g_stage[gi-1].valid_reg;
        assign last_in  = g_stage[gi-1].last_reg;
      end

      // Stage register: shifts forward on enable, bubbles travel as valid=0.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          prod_reg  <= '0;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
        end else if (ce) begin
          prod_reg  <= prod_in;
          valid_reg <= valid_in;
          last_reg  <= last_in;
        end
      end
    end
  endgenerate

  assign tail_prod  = g_stage[NUM_STAGE-1].prod_reg;
  assign tail_valid = g_stage[NUM_STAGE-1].valid_reg;
  assign tail_last  = g_stage[NUM_STAGE-1].last_reg;

  // Running sum wraps in ACC_WIDTH two's complement.
  assign sum_next    = acc_reg + ACC_WIDTH'(tail_prod);
  assign result_fire = tail_valid && tail_last;

  // Round half toward +inf, then arithmetic shift out the fraction bits.
  assign sum_ext      = {sum_next[ACC_WIDTH-1], sum_next};
  assign rnd_sum_next = (sum_ext + RND_BIAS) >>> FRAC_SHIFT;

  // Clip the rounded sum into the signed output range and flag clipping.
  always_comb begin
    sat_data_next = rnd_sum_next[OUT_WIDTH-1:0];
    sat_flag_next = 1'b0;
    if (rnd_sum_next > OUT_MAX) begin
      sat_data_next = OUT_MAX[OUT_WIDTH-1:0];
      sat_flag_next = 1'b1;
    end else if (rnd_sum_next < OUT_MIN) begin
      sat_data_next = OUT_MIN[OUT_WIDTH-1:0];
      sat_flag_next = 1'b1;
    end
  end

  // Accumulator: absorbs valid products, restarts from zero after a last beat.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_reg <= '0;
    end else if (ce && tail_valid) begin
      acc_reg <= tail_last ? '0 : sum_next;
    end
  end

  // Output register: loads a finished dot product, holds it until consumed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (ce) begin
      out_valid_reg <= result_fire;
      if (result_fire) begin
        out_data_reg <= sat_data_next;
        out_sat_reg  <= sat_flag_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// tb_cnn_mac_pipe: directed bench for cnn_mac_pipe. Two instances share the
// stimulus: one with 8 fraction bits, one with none. A dot-product model
// computes each expected result at acceptance time; a negedge monitor
// scores every output handshake and checks output hold under backpressure.
module tb_cnn_mac_pipe;
  localparam int NS = 3;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic signed [9:0]  in_a = '0;
  logic signed [13:0] in_b = '0;

  logic in_ready, out_valid, out_sat;
  logic signed [15:0] out_data;
  logic in_ready_f0, out_valid_f0, out_sat_f0;
  logic signed [15:0] out_data_f0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    longint data;
    longint sat;
  } res_t;

  res_t   q8[$];
  res_t   q0[$];
  longint log8[$];
  longint log0[$];
  int     sum8 = 0;
  int     sum0 = 0;
  int     hs_cnt = 0;
  bit     saw_stall = 1'b0;
  bit     prev_hold = 1'b0;
  logic signed [15:0] prev_data = '0;
  res_t   e;

  cnn_mac_pipe #(.NUM_STAGE(NS), .FRAC_SHIFT(8)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  cnn_mac_pipe #(.NUM_STAGE(NS), .FRAC_SHIFT(0)) dut_f0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready_f0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_f0), .out_ready(out_ready),
    .out_data(out_data_f0), .out_sat(out_sat_f0)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected output for a finished sum: round half up, shift, clip.
  function automatic res_t model_out(input int s, input int fs);
    longint r;
    res_t o;
    r = longint'(s) + ((fs > 0) ? (longint'(1) << (fs - 1)) : 64'sd0);
    r = r >>> fs;
    if (r > 32767) begin
      o.data = 32767; o.sat = 1;
    end else if (r < -32768) begin
      o.data = -32768; o.sat = 1;
    end else begin
      o.data = r; o.sat = 0;
    end
    return o;
  endfunction

  // Monitor: scores outputs, checks hold, and feeds accepted beats to the model.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_sat", out_sat, 0);
      check("reset_out_valid_f0", out_valid_f0, 0);
      sum8 = 0; sum0 = 0;
      q8.delete(); q0.delete();
      prev_hold = 1'b0;
    end else begin
      if (!in_ready) saw_stall = 1'b1;
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;

      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q8.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result8: got %0d, expected no result", out_data);
        end else begin
          e = q8.pop_front();
          check("data8", out_data, e.data);
          check("sat8", out_sat, e.sat);
        end
        log8.push_back(out_data);
      end
      if (out_valid_f0 && out_ready) begin
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result0: got %0d, expected no result", out_data_f0);
        end else begin
          e = q0.pop_front();
          check("data0", out_data_f0, e.data);
          check("sat0", out_sat_f0, e.sat);
        end
        log0.push_back(out_data_f0);
      end

      if (in_valid && in_ready) begin
        sum8 += int'(in_a) * int'(in_b);
        if (in_last) begin q8.push_back(model_out(sum8, 8)); sum8 = 0; end
      end
      if (in_valid && in_ready_f0) begin
        sum0 += int'(in_a) * int'(in_b);
        if (in_last) begin q0.push_back(model_out(sum0, 0)); sum0 = 0; end
      end
    end
  end

  // Present one beat and hold it until it is accepted.
  task automatic beat(input int a, input int b, input bit last);
    bit acc;
    int guard;
    guard = 0;
    in_valid = 1'b1; in_a = 10'(a); in_b = 14'(b); in_last = last;
    do begin
      @(negedge ap_clk);
      acc = in_ready;
      @(posedge ap_clk); #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL beat_timeout: got no acceptance, expected acceptance within 200 cycles");
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // One idle cycle with junk operands and a stray last flag.
  task automatic bubble();
    in_valid = 1'b0; in_a = 10'sd77; in_b = 14'sd99; in_last = 1'b1;
    @(posedge ap_clk); #1;
    in_last = 1'b0;
  endtask

  // Wait until every expected result has been delivered.
  task automatic drain();
    int guard;
    guard = 0;
    while ((q8.size() != 0 || q0.size() != 0) && guard < 200) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q8.size());
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic clear_logs();
    log8.delete(); log0.delete();
  endtask

  initial begin
    int lat;
    int guard;

    // Reset
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge ap_clk); #1;

    // Single beat with latency measurement
    clear_logs();
    in_valid = 1'b1; in_a = 10'sd3; in_b = 14'sd256; in_last = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    lat = 0;
    do begin
      @(negedge ap_clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", lat, NS + 1);
    drain();
    check("single_cnt", log8.size(), 1);
    if (log8.size() == 1) check("single_data8", log8[0], 3);
    if (log0.size() == 1) check("single_data0", log0[0], 768);

    // Three-beat dot product followed at once by a single beat
    clear_logs();
    beat(100, 200, 0);
    beat(-50, 300, 0);
    beat(7, -1000, 1);
    beat(1, 256, 1);
    drain();
    check("dot3_cnt", log8.size(), 2);
    if (log8.size() == 2) begin
      check("dot3_data8", log8[0], -8);
      check("after_dot3_data8", log8[1], 1);
    end
    if (log0.size() == 2) check("dot3_data0", log0[0], -2000);

    // Positive and negative saturation
    clear_logs();
    for (int i = 0; i < 8; i++) beat(-512, -8192, i == 7);
    drain();
    check("satpos_data8", out_data, 32767);
    check("satpos_sat8", out_sat, 1);
    for (int i = 0; i < 8; i++) beat(-512, 8191, i == 7);
    drain();
    check("satneg_data8", out_data, -32768);
    check("satneg_sat8", out_sat, 1);
    check("satneg_sat0", out_sat_f0, 1);

    // Backpressure while single-beat results stream
    clear_logs();
    saw_stall = 1'b0;
    fork
      for (int i = 1; i <= 10; i++) beat(i, 256, 1);
      begin
        repeat (3) @(posedge ap_clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge ap_clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_stall_seen", saw_stall, 1);
    check("bp_cnt", log8.size(), 10);
    for (int i = 0; i < log8.size() && i < 10; i++) check("bp_order8", log8[i], i + 1);

    // Bubbles inside a four-beat dot product
    clear_logs();
    beat(1, 1, 0); bubble();
    beat(1, 1, 0); bubble();
    beat(1, 1, 0); bubble();
    beat(1, 1, 1);
    drain();
    check("bubble_cnt", log8.size(), 1);
    if (log8.size() == 1) check("bubble_data8", log8[0], 0);
    if (log0.size() == 1) check("bubble_data0", log0[0], 4);

    // Reset with a pending result and a partial sum in flight
    out_ready = 1'b0;
    beat(1, 256, 1);
    beat(5, 256, 0);
    beat(5, 256, 0);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    check("pending_before_reset", out_valid, 1);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_valid_f0", out_valid_f0, 0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1; out_ready = 1'b1;
    clear_logs();
    beat(2, 512, 1);
    drain();
    check("post_reset_cnt", log8.size(), 1);
    if (log8.size() == 1) check("post_reset_data8", log8[0], 4);
    if (log0.size() == 1) check("post_reset_data0", log0[0], 1024);

    check("final_queue8", q8.size(), 0);
    check("final_queue0", q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
